// File: rtl/connect4_pkg.sv
// Shared types and geometry for the Connect-4 game controller.
package connect4_pkg;

  localparam int unsigned ROWS      = 6;
  localparam int unsigned COLS      = 7;
  localparam int unsigned WIN_LEN   = 4;
  localparam int unsigned START_COL = 3;

  localparam int unsigned ROW_W = $clog2(ROWS);
  localparam int unsigned COL_W = $clog2(COLS);
  localparam int unsigned HGT_W = $clog2(ROWS + 1);
  localparam int unsigned MOV_W = $clog2(ROWS * COLS + 1);
  localparam int unsigned RUN_W = $clog2(WIN_LEN);
  localparam int unsigned SUM_W = RUN_W + 2;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    P0    = 2'b01,
    P1    = 2'b10
  } cell_t;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    W0   = 2'b01,
    W1   = 2'b10,
    DRAW = 2'b11
  } winner_t;

  typedef enum logic [1:0] {
    PLAY    = 2'd0,
    CHK     = 2'd1,
    RESOLVE = 2'd2,
    OVER    = 2'd3
  } state_t;

  // Scan directions: horizontal, vertical, rising diagonal, falling diagonal.
  typedef enum logic [1:0] {
    DIR_H  = 2'd0,
    DIR_V  = 2'd1,
    DIR_DU = 2'd2,
    DIR_DD = 2'd3
  } dir_t;

  typedef logic signed [1:0] delta_t;

  typedef logic [ROWS-1:0][COLS-1:0][1:0] board_t;

  // Position of the most recent drop.
  typedef struct packed {
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
  } pos_t;

  // Row step for a scan direction.
  function automatic delta_t dir_drow(input dir_t d);
    delta_t step;
    step = 2'sb01;
    if (d == DIR_H) step = 2'sb00;
    return step;
  endfunction

  // Column step for a scan direction; the falling diagonal walks up-left.
  function automatic delta_t dir_dcol(input dir_t d);
    delta_t step;
    case (d)
      DIR_V:   step = 2'sb00;
      DIR_DD:  step = 2'sb11;
      default: step = 2'sb01;
    endcase
    return step;
  endfunction

endpackage

// File: rtl/run_counter.sv
// Counts same-colour cells contiguous to the drop cell along one step direction.
module run_counter
  import connect4_pkg::*;
(
  input  board_t           i_board,
  input  pos_t             i_pos,
  input  delta_t           i_drow,
  input  delta_t           i_dcol,
  input  cell_t            i_colour,
  output logic [RUN_W-1:0] o_run_c
);

  int   w_r;
  int   w_c;
  logic w_live;
  logic w_inb;

  // Walk outward up to WIN_LEN-1 cells, stopping at the edge or a colour change.
  always_comb begin
    o_run_c = '0;
    w_live  = 1'b1;
    w_r     = 0;
    w_c     = 0;
    w_inb   = 1'b0;
    for (int k = 1; k < int'(WIN_LEN); k++) begin
      w_r   = int'(i_pos.row) + k * int'(i_drow);
      w_c   = int'(i_pos.col) + k * int'(i_dcol);
      w_inb = (w_r >= 0) && (w_r < int'(ROWS)) && (w_c >= 0) && (w_c < int'(COLS));
      if (w_live && w_inb && (i_board[ROW_W'(w_r)][COL_W'(w_c)] == i_colour)) begin
        o_run_c = o_run_c + RUN_W'(1);
      end else begin
        w_live = 1'b0;
      end
    end
  end

endmodule

// File: rtl/game_engine.sv
// Connect-4 controller: buttons to cursor/drops, board state, win scan and result.
module game_engine
  import connect4_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           left,
  input  logic                           right,
  input  logic                           put,
  input  logic                           restart,
  output logic [ROWS-1:0][COLS-1:0][1:0] panel,
  output logic [COLS-1:0]                play,
  output logic                           player,
  output logic [1:0]                     winner
);

  localparam logic [COLS-1:0] PLAY_RST = COLS'(1) << START_COL;

  state_t            r_state,  w_state_nxt;
  dir_t              r_dir,    w_dir_nxt;
  board_t            r_board,  w_board_nxt;
  logic [HGT_W-1:0]  r_height [COLS];
  logic [HGT_W-1:0]  w_height_nxt [COLS];
  logic [MOV_W-1:0]  r_moves,  w_moves_nxt;
  logic              r_player, w_player_nxt;
  winner_t           r_winner, w_winner_nxt;
  logic [COLS-1:0]   r_play,   w_play_nxt;
  pos_t              r_drop,   w_drop_nxt;
  logic              r_win,    w_win_nxt;
  logic [3:0]        r_btn_prev;

  logic [3:0]        w_btn;
  logic [3:0]        w_edge;
  logic              w_left_e;
  logic              w_right_e;
  logic              w_put_e;
  logic              w_restart_e;
  logic [COLS-1:0]   w_play_moved;
  logic [COL_W-1:0]  w_col;
  logic [HGT_W-1:0]  w_top;
  logic              w_full;
  cell_t             w_colour;
  delta_t            w_drow;
  delta_t            w_dcol;
  delta_t            w_drow_n;
  delta_t            w_dcol_n;
  logic [RUN_W-1:0]  w_run_pos;
  logic [RUN_W-1:0]  w_run_neg;
  logic [SUM_W-1:0]  w_sum;
  logic              w_hit;

  assign w_btn       = {restart, put, right, left};
  assign w_edge      = w_btn & ~r_btn_prev;
  assign w_left_e    = w_edge[0];
  assign w_right_e   = w_edge[1];
  assign w_put_e     = w_edge[2];
  assign w_restart_e = w_edge[3];

  assign w_colour = r_player ? P1 : P0;
  assign w_drow   = dir_drow(r_dir);
  assign w_dcol   = dir_dcol(r_dir);
  assign w_drow_n = -w_drow;
  assign w_dcol_n = -w_dcol;

  run_counter u_run_pos (
    .i_board  (r_board),
    .i_pos    (r_drop),
    .i_drow   (w_drow),
    .i_dcol   (w_dcol),
    .i_colour (w_colour),
    .o_run_c  (w_run_pos)
  );

  run_counter u_run_neg (
    .i_board  (r_board),
    .i_pos    (r_drop),
    .i_drow   (w_drow_n),
    .i_dcol   (w_dcol_n),
    .i_colour (w_colour),
    .o_run_c  (w_run_neg)
  );

  assign w_sum = SUM_W'(w_run_pos) + SUM_W'(w_run_neg) + SUM_W'(1);
  assign w_hit = (w_sum >= SUM_W'(WIN_LEN));

  // Binary column index of the one-hot cursor.
  always_comb begin
    w_col = '0;
    for (int i = 0; i < int'(COLS); i++) begin
      if (r_play[i]) w_col = COL_W'(i);
    end
  end

  assign w_top  = r_height[w_col];
  assign w_full = (w_top == HGT_W'(ROWS));

  // Saturating cursor shift; simultaneous left and right cancel.
  always_comb begin
    w_play_moved = r_play;
    if (w_left_e && !w_right_e && !r_play[0]) begin
      w_play_moved = r_play >> 1;
    end else if (w_right_e && !w_left_e && !r_play[COLS-1]) begin
      w_play_moved = r_play << 1;
    end
  end

  // Next-state and datapath updates; a restart edge overrides everything.
  always_comb begin
    w_state_nxt  = r_state;
    w_dir_nxt    = r_dir;
    w_board_nxt  = r_board;
    w_height_nxt = r_height;
    w_moves_nxt  = r_moves;
    w_player_nxt = r_player;
    w_winner_nxt = r_winner;
    w_play_nxt   = r_play;
    w_drop_nxt   = r_drop;
    w_win_nxt    = r_win;

    case (r_state)
      PLAY: begin
        if (w_put_e) begin
          if (!w_full) begin
            w_board_nxt[ROW_W'(w_top)][w_col] = w_colour;
            w_height_nxt[w_col] = w_top + HGT_W'(1);
            w_moves_nxt         = r_moves + MOV_W'(1);
            w_drop_nxt.row      = ROW_W'(w_top);
            w_drop_nxt.col      = w_col;
            w_dir_nxt           = DIR_H;
            w_win_nxt           = 1'b0;
            w_state_nxt         = CHK;
          end
        end else begin
          w_play_nxt = w_play_moved;
        end
      end
      CHK: begin
        if (w_hit) w_win_nxt = 1'b1;
        w_dir_nxt = dir_t'(2'(r_dir) + 2'd1);
        if (r_dir == DIR_DD) w_state_nxt = RESOLVE;
      end
      RESOLVE: begin
        if (r_win) begin
          w_winner_nxt = r_player ? W1 : W0;
          w_state_nxt  = OVER;
        end else if (r_moves == MOV_W'(ROWS * COLS)) begin
          w_winner_nxt = DRAW;
          w_state_nxt  = OVER;
        end else begin
          w_player_nxt = ~r_player;
          w_win_nxt    = 1'b0;
          w_state_nxt  = PLAY;
        end
      end
      OVER: begin
        w_play_nxt = w_play_moved;
      end
      default: w_state_nxt = PLAY;
    endcase

    if (w_restart_e) begin
      w_state_nxt  = PLAY;
      w_dir_nxt    = DIR_H;
      w_board_nxt  = '0;
      w_height_nxt = '{default: '0};
      w_moves_nxt  = '0;
      w_player_nxt = 1'b0;
      w_winner_nxt = NONE;
      w_play_nxt   = PLAY_RST;
      w_drop_nxt   = '0;
      w_win_nxt    = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= PLAY;
      r_dir    <= DIR_H;
      r_board  <= '0;
      r_height <= '{default: '0};
      r_moves  <= '0;
      r_player <= 1'b0;
      r_winner <= NONE;
      r_play   <= PLAY_RST;
      r_drop   <= '0;
      r_win    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_dir    <= w_dir_nxt;
      r_board  <= w_board_nxt;
      r_height <= w_height_nxt;
      r_moves  <= w_moves_nxt;
      r_player <= w_player_nxt;
      r_winner <= w_winner_nxt;
      r_play   <= w_play_nxt;
      r_drop   <= w_drop_nxt;
      r_win    <= w_win_nxt;
    end
  end

  // Button history for rising-edge detection.
  always_ff @(posedge clk) begin
    if (rst) r_btn_prev <= '0;
    else     r_btn_prev <= w_btn;
  end

  assign panel  = r_board;
  assign play   = r_play;
  assign player = r_player;
  assign winner = r_winner;

endmodule
